// File: rtl/phy_mem_arb_pkg.sv
// Shared types and helpers for the two-port physical-memory arbiter.
// State encoding, port indices, default park address and the alignment check.
package phy_mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        WR_PULSE = 3'd2,
        WR_WAIT  = 3'd3,
        ACK      = 3'd4
    } state_e;

    localparam logic PORT_D = 1'b0;
    localparam logic PORT_I = 1'b1;

    localparam logic [31:0] DEF_PARK_ADDR = 32'h0000_0000;

    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-requester round-robin picker: combinational one-hot grant, pointer updated on strobe.
// Zero latency; with both requesting, the port not granted last wins.
module arb_rr2
    import phy_mem_arb_pkg::*;
(
    input  logic       clk50M,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       update,
    output logic [1:0] grant
);

    logic last_q;
    logic last_d;

    always_comb begin
        last_d = update ? last_grant : last_q;
    end

    // Reset as if I was granted last, so D wins the first contention.
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= PORT_I;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_q == PORT_D) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/phy_mem_arbiter.sv
// Shares one phy_mem_ctrl port between fetch (I) and load/store (D) requesters.
// Read ack at grant+READ_WAIT+1, write ack one cycle after busy drops; address parked while idle.
module phy_mem_arbiter
    import phy_mem_arb_pkg::*;
#(
    parameter int unsigned    READ_WAIT  = 1,
    parameter int unsigned    WR_TIMEOUT = 15,
    parameter logic [31:0]    PARK_ADDR  = DEF_PARK_ADDR
) (
    input  logic        clk50M,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_err,
    output logic        mem_is_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    input  logic        mem_busy
);

    localparam logic [3:0] RD_LAST = 4'(READ_WAIT - 1);
    localparam logic [3:0] WR_LAST = 4'(WR_TIMEOUT - 2);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        port_q;
    logic        err_q;
    logic [31:0] i_rdata_q;
    logic        i_ack_q;
    logic        i_err_q;
    logic [31:0] d_rdata_q;
    logic        d_ack_q;
    logic        d_err_q;
    logic        mem_is_write_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_data_in_q;

    logic [1:0]  grant;
    logic        sel_port;
    logic        sel_we;
    logic [31:0] sel_addr;

    arb_rr2 u_arb (
        .clk50M     (clk50M),
        .rst_n      (rst_n),
        .req        ({i_req, d_req}),
        .last_grant (port_q),
        .update     (state_q == ACK),
        .grant      (grant)
    );

    always_comb begin
        sel_port = grant[PORT_I];
        sel_we   = (sel_port == PORT_D) && d_we;
        sel_addr = (sel_port == PORT_I) ? i_addr : d_addr;
    end

    // Ack is registered in the ACK state, so it lands one edge after ACK is entered.
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= 4'd0;
            port_q         <= PORT_D;
            err_q          <= 1'b0;
            i_rdata_q      <= 32'd0;
            i_ack_q        <= 1'b0;
            i_err_q        <= 1'b0;
            d_rdata_q      <= 32'd0;
            d_ack_q        <= 1'b0;
            d_err_q        <= 1'b0;
            mem_is_write_q <= 1'b0;
            mem_addr_q     <= PARK_ADDR;
            mem_data_in_q  <= 32'd0;
        end else begin
            i_ack_q        <= 1'b0;
            i_err_q        <= 1'b0;
            d_ack_q        <= 1'b0;
            d_err_q        <= 1'b0;
            mem_is_write_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant != 2'b00) begin
                        port_q <= sel_port;
                        cnt_q  <= 4'd0;
                        if (!is_aligned(sel_addr)) begin
                            err_q   <= 1'b1;
                            state_q <= ACK;
                        end else begin
                            err_q      <= 1'b0;
                            mem_addr_q <= sel_addr;
                            if (sel_we) begin
                                mem_data_in_q  <= d_wdata;
                                mem_is_write_q <= 1'b1;
                                state_q        <= WR_PULSE;
                            end else begin
                                state_q <= RD_WAIT;
                            end
                        end
                    end
                end
                RD_WAIT: begin
                    if (cnt_q == RD_LAST) begin
                        if (port_q == PORT_I) begin
                            i_rdata_q <= mem_data_out;
                        end else begin
                            d_rdata_q <= mem_data_out;
                        end
                        mem_addr_q <= PARK_ADDR;
                        state_q    <= ACK;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                WR_PULSE: begin
                    state_q <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (!mem_busy) begin
                        mem_addr_q <= PARK_ADDR;
                        state_q    <= ACK;
                    end else if (cnt_q == WR_LAST) begin
                        err_q      <= 1'b1;
                        mem_addr_q <= PARK_ADDR;
                        state_q    <= ACK;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ACK: begin
                    if (port_q == PORT_I) begin
                        i_ack_q <= 1'b1;
                        i_err_q <= err_q;
                    end else begin
                        d_ack_q <= 1'b1;
                        d_err_q <= err_q;
                    end
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign i_rdata      = i_rdata_q;
    assign i_ack        = i_ack_q;
    assign i_err        = i_err_q;
    assign d_rdata      = d_rdata_q;
    assign d_ack        = d_ack_q;
    assign d_err        = d_err_q;
    assign mem_is_write = mem_is_write_q;
    assign mem_addr     = mem_addr_q;
    assign mem_data_in  = mem_data_in_q;

endmodule

// File: tb/tb_phy_mem_arbiter.sv
// Directed bench for phy_mem_arbiter with hand-computed cycle positions and data.
module tb_phy_mem_arbiter;

    logic        clk50M = 1'b0;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        d_err;
    logic        mem_is_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_busy;

    logic        mem_mode;
    logic [31:0] mem_fix;

    int total = 0;
    int bad   = 0;

    assign mem_data_out = mem_mode ? (mem_addr ^ 32'hA5A5_0000) : mem_fix;

    always #10 clk50M = ~clk50M;

    phy_mem_arbiter #(
        .READ_WAIT  (1),
        .WR_TIMEOUT (15),
        .PARK_ADDR  (32'h0000_0000)
    ) dut (
        .clk50M       (clk50M),
        .rst_n        (rst_n),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_rdata      (i_rdata),
        .i_ack        (i_ack),
        .i_err        (i_err),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_ack        (d_ack),
        .d_err        (d_err),
        .mem_is_write (mem_is_write),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_busy     (mem_busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk50M);
        #1;
    endtask

    // n = number of edges from the request drive point up to and including the ack edge
    task automatic wait_ack(input logic port_i, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(port_i ? i_ack : d_ack) && n < 40);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int k;
        int acks;
        logic got[4];
        logic saw_addr;
        logic saw_wr;

        rst_n    = 1'b0;
        i_req    = 1'b0;
        i_addr   = 32'd0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_addr   = 32'd0;
        d_wdata  = 32'd0;
        mem_busy = 1'b0;
        mem_mode = 1'b0;
        mem_fix  = 32'd0;

        #5;
        check_val("rst_mem_addr", mem_addr, 32'h0);
        check_val("rst_is_write", {31'd0, mem_is_write}, 32'h0);
        check_val("rst_data_in", mem_data_in, 32'h0);
        check_val("rst_acks", {28'd0, i_ack, i_err, d_ack, d_err}, 32'h0);
        check_val("rst_rdata", i_rdata | d_rdata, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // I read, READ_WAIT=1
        mem_fix = 32'hDEAD_BEEF;
        i_addr  = 32'h0000_0100;
        i_req   = 1'b1;
        check_val("rd_park_before", mem_addr, 32'h0);
        tick();
        check_val("rd_addr_e0", mem_addr, 32'h0000_0100);
        tick();
        check_val("rd_noack_e1", {31'd0, i_ack}, 32'h0);
        tick();
        check_val("rd_ack_e2", {31'd0, i_ack}, 32'h1);
        check_val("rd_rdata", i_rdata, 32'hDEAD_BEEF);
        check_val("rd_err", {31'd0, i_err}, 32'h0);
        check_val("rd_no_dack", {31'd0, d_ack}, 32'h0);
        i_req = 1'b0;
        tick();
        check_val("rd_park_after", mem_addr, 32'h0);
        check_val("rd_ack_pulse", {31'd0, i_ack}, 32'h0);

        // Continuous contention, both reading
        mem_mode = 1'b1;
        i_addr   = 32'h0000_0104;
        d_addr   = 32'h0000_0208;
        d_we     = 1'b0;
        i_req    = 1'b1;
        d_req    = 1'b1;
        k = 0;
        for (int c = 0; c < 40 && k < 4; c++) begin
            tick();
            if (i_ack || d_ack) begin
                check_val("rr_one_ack", {31'd0, i_ack & d_ack}, 32'h0);
                got[k] = i_ack;
                if (i_ack) check_val("rr_i_rdata", i_rdata, 32'hA5A5_0104);
                else       check_val("rr_d_rdata", d_rdata, 32'hA5A5_0208);
                k++;
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        check_val("rr_count", k, 4);
        for (int j = 0; j < 4; j++) begin
            check_val($sformatf("rr_order%0d", j), {31'd0, got[j]}, (j % 2 == 1) ? 32'h1 : 32'h0);
        end
        tick();

        // D write with busy for three cycles
        d_we    = 1'b1;
        d_addr  = 32'h0000_0200;
        d_wdata = 32'h1234_5678;
        d_req   = 1'b1;
        tick();
        check_val("wr_is_write_e0", {31'd0, mem_is_write}, 32'h1);
        check_val("wr_addr_e0", mem_addr, 32'h0000_0200);
        check_val("wr_data_e0", mem_data_in, 32'h1234_5678);
        mem_busy = 1'b1;
        tick();
        check_val("wr_is_write_e1", {31'd0, mem_is_write}, 32'h0);
        check_val("wr_addr_e1", mem_addr, 32'h0000_0200);
        tick();
        check_val("wr_noack_e2", {31'd0, d_ack}, 32'h0);
        tick();
        mem_busy = 1'b0;
        tick();
        check_val("wr_noack_e4", {31'd0, d_ack}, 32'h0);
        tick();
        check_val("wr_ack_e5", {31'd0, d_ack}, 32'h1);
        check_val("wr_err", {31'd0, d_err}, 32'h0);
        check_val("wr_rdata_hold", d_rdata, 32'hA5A5_0208);
        d_req = 1'b0;
        d_we  = 1'b0;
        tick();

        // Write timeout with busy stuck high
        mem_busy = 1'b1;
        d_we     = 1'b1;
        d_addr   = 32'h0000_0300;
        d_wdata  = 32'h0000_55AA;
        d_req    = 1'b1;
        wait_ack(1'b0, n);
        check_val("to_latency", n, 17);
        check_val("to_err", {31'd0, d_err}, 32'h1);
        d_req    = 1'b0;
        d_we     = 1'b0;
        mem_busy = 1'b0;
        tick();
        check_val("to_park", mem_addr, 32'h0);
        check_val("to_is_write", {31'd0, mem_is_write}, 32'h0);

        // Unaligned D read: no memory access at all
        d_addr   = 32'h0000_0202;
        d_req    = 1'b1;
        saw_addr = 1'b0;
        saw_wr   = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
            if (mem_addr != 32'h0) saw_addr = 1'b1;
            if (mem_is_write)      saw_wr   = 1'b1;
        end while (!d_ack && n < 10);
        check_val("ua_latency", n, 2);
        check_val("ua_err", {31'd0, d_err}, 32'h1);
        check_val("ua_addr_moved", {31'd0, saw_addr}, 32'h0);
        check_val("ua_wr_seen", {31'd0, saw_wr}, 32'h0);
        check_val("ua_rdata_hold", d_rdata, 32'hA5A5_0208);
        d_req = 1'b0;
        tick();

        // Unaligned I read
        i_addr = 32'h0000_0101;
        i_req  = 1'b1;
        wait_ack(1'b1, n);
        check_val("ua_i_latency", n, 2);
        check_val("ua_i_err", {31'd0, i_err}, 32'h1);
        i_req = 1'b0;
        tick();

        // Reset in WR_WAIT, then a normal write
        mem_busy = 1'b1;
        d_we     = 1'b1;
        d_addr   = 32'h0000_0400;
        d_wdata  = 32'h1111_2222;
        d_req    = 1'b1;
        tick();
        tick();
        tick();
        rst_n    = 1'b0;
        d_req    = 1'b0;
        mem_busy = 1'b0;
        #2;
        check_val("ar_mem_addr", mem_addr, 32'h0);
        check_val("ar_is_write", {31'd0, mem_is_write}, 32'h0);
        check_val("ar_data_in", mem_data_in, 32'h0);
        check_val("ar_rdata", i_rdata | d_rdata, 32'h0);
        acks = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (i_ack || d_ack) acks++;
        end
        check_val("ar_no_ack", acks, 0);
        rst_n = 1'b1;
        tick();
        d_addr  = 32'h0000_0404;
        d_wdata = 32'hCAFE_0001;
        d_req   = 1'b1;
        tick();
        check_val("ar_wr_pulse", {31'd0, mem_is_write}, 32'h1);
        check_val("ar_wr_data", mem_data_in, 32'hCAFE_0001);
        wait_ack(1'b0, n);
        check_val("ar_wr_latency", n, 3);
        check_val("ar_wr_err", {31'd0, d_err}, 32'h0);
        d_req = 1'b0;
        d_we  = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
